// File: rtl/if_fetch_ctrl.sv
// IF-stage fetch controller: owns the PC and the IF/ID register, issues a single outstanding
// imem fetch, skids a response across an ID stall and drops stale responses after a redirect.
// Optional perf counters are enabled by defining IF_FETCH_PERF_EN.
module if_fetch_ctrl #(
   parameter logic [31:0] RESET_PC     = 32'h0000_0000,
   parameter logic [31:0] BUBBLE_INSTR = 32'h0000_0000
) (
   input  logic        clk_i,
   input  logic        rst_i,
   input  logic        stall_i,
   input  logic        flush_i,
   input  logic [31:0] branch_target_i,
   output logic        imem_req_o,
   output logic [31:0] imem_addr_o,
   input  logic        imem_ready_i,
   input  logic        imem_valid_i,
   input  logic [31:0] imem_rdata_i,
`ifdef IF_FETCH_PERF_EN
   output logic [31:0] perf_stall_cnt_o,
   output logic [31:0] perf_wait_cnt_o,
`endif
   output logic [31:0] ID_pc_o,
   output logic [31:0] ID_instr_o,
   output logic        ID_valid_o
);

   localparam int unsigned XLEN = 32;

   typedef enum logic [1:0] {S_REQ, S_WAIT, S_HOLD, S_DROP} state_t;

   state_t            state, state_n;
   logic [XLEN-1:0]   pc, pc_n;
   logic [XLEN-1:0]   skid_pc, skid_pc_n;
   logic [XLEN-1:0]   skid_instr, skid_instr_n;
   logic [XLEN-1:0]   id_pc_n, id_instr_n;
   logic              id_valid_n;
   logic              deliver;
   logic [XLEN-1:0]   dlv_pc, dlv_instr;

   // Request is gated by reset so nothing is issued while rst_i is low.
   assign imem_req_o  = rst_i & (state == S_REQ) & ~flush_i;
   assign imem_addr_o = pc;

   always_ff @(posedge clk_i or negedge rst_i) begin
      if (!rst_i) begin
         state      <= S_REQ;
         pc         <= RESET_PC;
         skid_pc    <= '0;
         skid_instr <= '0;
         ID_pc_o    <= '0;
         ID_instr_o <= BUBBLE_INSTR;
         ID_valid_o <= 1'b0;
      end else begin
         state      <= state_n;
         pc         <= pc_n;
         skid_pc    <= skid_pc_n;
         skid_instr <= skid_instr_n;
         ID_pc_o    <= id_pc_n;
         ID_instr_o <= id_instr_n;
         ID_valid_o <= id_valid_n;
      end
   end

   // Next-state, PC and delivery decode; a redirect always overrides PC advance.
   always_comb begin
      state_n      = state;
      pc_n         = pc;
      skid_pc_n    = skid_pc;
      skid_instr_n = skid_instr;
      deliver      = 1'b0;
      dlv_pc       = pc;
      dlv_instr    = imem_rdata_i;
      case (state)
         S_REQ: begin
            if (flush_i)           pc_n    = branch_target_i;
            else if (imem_ready_i) state_n = S_WAIT;
         end
         S_WAIT: begin
            if (flush_i) begin
               pc_n    = branch_target_i;
               state_n = imem_valid_i ? S_REQ : S_DROP;
            end else if (imem_valid_i) begin
               if (stall_i) begin
                  skid_pc_n    = pc;
                  skid_instr_n = imem_rdata_i;
                  state_n      = S_HOLD;
               end else begin
                  deliver = 1'b0 | 1'b1;
                  pc_n    = pc + XLEN'(4);
                  state_n = S_REQ;
               end
            end
         end
         S_HOLD: begin
            if (flush_i) begin
               pc_n    = branch_target_i;
               state_n = S_REQ;
            end else if (!stall_i) begin
               deliver   = 1'b1;
               dlv_pc    = skid_pc;
               dlv_instr = skid_instr;
               pc_n      = pc + XLEN'(4);
               state_n   = S_REQ;
            end
         end
         S_DROP: begin
            if (flush_i)      pc_n    = branch_target_i;
            if (imem_valid_i) state_n = S_REQ;
         end
         default: state_n = S_REQ;
      endcase
   end

   // IF/ID update: flush, then stall hold, then new instruction, else bubble.
   always_comb begin
      id_pc_n    = ID_pc_o;
      id_instr_n = BUBBLE_INSTR;
      id_valid_n = 1'b0;
      if (flush_i) begin
         id_pc_n = pc;
      end else if (stall_i) begin
         id_instr_n = ID_instr_o;
         id_valid_n = ID_valid_o;
      end else if (deliver) begin
         id_pc_n    = dlv_pc;
         id_instr_n = dlv_instr;
         id_valid_n = 1'b1;
      end
   end

`ifdef IF_FETCH_PERF_EN
   logic wait_cyc;
   assign wait_cyc = ((state == S_WAIT) || (state == S_DROP)) & ~imem_valid_i;

   // Saturating event counters.
   always_ff @(posedge clk_i or negedge rst_i) begin
      if (!rst_i) begin
         perf_stall_cnt_o <= '0;
         perf_wait_cnt_o  <= '0;
      end else begin
         if (stall_i && (perf_stall_cnt_o != '1))
            perf_stall_cnt_o <= perf_stall_cnt_o + XLEN'(1);
         if (wait_cyc && (perf_wait_cnt_o != '1))
            perf_wait_cnt_o <= perf_wait_cnt_o + XLEN'(1);
      end
   end
`endif

endmodule

// File: tb/tb_if_fetch_ctrl.sv
// Bench for if_fetch_ctrl: directed vector table, reset-in-hold sequence, and randomized
// traffic checked against a transaction-level model of the fetch front end.
module tb_if_fetch_ctrl;

   localparam logic [31:0] RST_PC = 32'hFFFF_FFFC;
   localparam logic [31:0] BUB    = 32'h0000_0013;
   localparam int          NVEC   = 20;
   localparam int          NRAND  = 4000;

   logic        clk = 1'b0;
   logic        rst_n;
   logic        stall, flush, ready, valid;
   logic [31:0] target, rdata;
   logic        req;
   logic [31:0] addr, id_pc, id_instr;
   logic        id_valid;
`ifdef IF_FETCH_PERF_EN
   logic [31:0] pstall, pwait;
`endif

   int checks = 0;
   int errors = 0;

   if_fetch_ctrl #(.RESET_PC(RST_PC), .BUBBLE_INSTR(BUB)) dut (
      .clk_i(clk), .rst_i(rst_n), .stall_i(stall), .flush_i(flush),
      .branch_target_i(target), .imem_req_o(req), .imem_addr_o(addr),
      .imem_ready_i(ready), .imem_valid_i(valid), .imem_rdata_i(rdata),
`ifdef IF_FETCH_PERF_EN
      .perf_stall_cnt_o(pstall), .perf_wait_cnt_o(pwait),
`endif
      .ID_pc_o(id_pc), .ID_instr_o(id_instr), .ID_valid_o(id_valid)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic        s, f;
      logic [31:0] t;
      logic        r, v;
      logic [31:0] d;
      logic        e_req;
      logic [31:0] e_addr;
      logic        e_val;
      logic [31:0] e_pc, e_instr;
   } vec_t;

   vec_t tbl [NVEC];

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %08h expected %08h (t=%0t)", name, act, exp, $time);
      end
   endtask

   function automatic vec_t mkv(input logic s, input logic f, input logic [31:0] t,
                                input logic r, input logic v, input logic [31:0] d,
                                input logic er, input logic [31:0] ea, input logic ev,
                                input logic [31:0] ep, input logic [31:0] ei);
      vec_t x;
      x.s = s; x.f = f; x.t = t; x.r = r; x.v = v; x.d = d;
      x.e_req = er; x.e_addr = ea; x.e_val = ev; x.e_pc = ep; x.e_instr = ei;
      return x;
   endfunction

   function automatic logic [31:0] mem_word(input logic [31:0] a);
      return (a * 32'h9E37_79B1) ^ 32'h5A5A_1234;
   endfunction

   task automatic apply(input logic s, input logic f, input logic [31:0] t,
                        input logic r, input logic v, input logic [31:0] d);
      @(negedge clk);
      stall = s; flush = f; target = t; ready = r; valid = v; rdata = d;
   endtask

   // Transaction-level reference state
   logic [31:0] m_pc, m_req_pc, m_buf_instr, m_id_pc, m_id_instr, pc_old, dlv_instr;
   logic        m_out, m_stale, m_buf, m_id_valid, req_exp, dlv;
   int unsigned m_stall_cnt, m_wait_cnt;
   logic        mp;
   logic [31:0] ma;
   int          mw;

   initial begin
      tbl[0]  = mkv(0,0,32'h0,  1,0,32'h0,        1,RST_PC,  0,32'h0,    BUB);
      tbl[1]  = mkv(0,0,32'h0,  1,1,32'h1111_0001,0,RST_PC,  1,RST_PC,   32'h1111_0001);
      tbl[2]  = mkv(0,0,32'h0,  1,0,32'h0,        1,32'h0,   0,32'h0,    BUB);
      tbl[3]  = mkv(0,0,32'h0,  1,1,32'h2222_0002,0,32'h0,   1,32'h0,    32'h2222_0002);
      tbl[4]  = mkv(0,0,32'h0,  0,0,32'h0,        1,32'h4,   0,32'h0,    BUB);
      tbl[5]  = mkv(0,0,32'h0,  1,0,32'h0,        1,32'h4,   0,32'h0,    BUB);
      tbl[6]  = mkv(1,0,32'h0,  1,1,32'h3333_0003,0,32'h4,   0,32'h0,    BUB);
      tbl[7]  = mkv(1,0,32'h0,  1,0,32'h0,        0,32'h4,   0,32'h0,    BUB);
      tbl[8]  = mkv(1,0,32'h0,  1,0,32'h0,        0,32'h4,   0,32'h0,    BUB);
      tbl[9]  = mkv(0,0,32'h0,  1,0,32'h0,        0,32'h4,   1,32'h4,    32'h3333_0003);
      tbl[10] = mkv(1,0,32'h0,  1,0,32'h0,        1,32'h8,   1,32'h4,    32'h3333_0003);
      tbl[11] = mkv(0,1,32'h100,1,0,32'h0,        0,32'h8,   0,32'h0,    BUB);
      tbl[12] = mkv(0,0,32'h0,  1,0,32'h0,        0,32'h100, 0,32'h0,    BUB);
      tbl[13] = mkv(0,0,32'h0,  1,1,32'h4444_0004,0,32'h100, 0,32'h0,    BUB);
      tbl[14] = mkv(0,0,32'h0,  1,0,32'h0,        1,32'h100, 0,32'h0,    BUB);
      tbl[15] = mkv(1,1,32'h200,1,1,32'h5555_0005,0,32'h100, 0,32'h0,    BUB);
      tbl[16] = mkv(0,0,32'h0,  1,0,32'h0,        1,32'h200, 0,32'h0,    BUB);
      tbl[17] = mkv(0,0,32'h0,  1,1,32'h6666_0006,0,32'h200, 1,32'h200,  32'h6666_0006);
      tbl[18] = mkv(0,1,32'h300,1,0,32'h0,        0,32'h204, 0,32'h0,    BUB);
      tbl[19] = mkv(0,0,32'h0,  1,0,32'h0,        1,32'h300, 0,32'h0,    BUB);

      rst_n = 1'b0;
      stall = 0; flush = 0; target = '0; ready = 0; valid = 0; rdata = '0;
      #12;
      chk("rst req",      32'(req),      32'h0);
      chk("rst addr",     addr,          RST_PC);
      chk("rst id_valid", 32'(id_valid), 32'h0);
      chk("rst id_instr", id_instr,      BUB);
      chk("rst id_pc",    id_pc,         32'h0);
      @(negedge clk);
      rst_n = 1'b1;

      // Directed per-cycle vectors
      for (int i = 0; i < NVEC; i++) begin
         apply(tbl[i].s, tbl[i].f, tbl[i].t, tbl[i].r, tbl[i].v, tbl[i].d);
         #1;
         chk($sformatf("vec%0d req", i),  32'(req), 32'(tbl[i].e_req));
         chk($sformatf("vec%0d addr", i), addr,     tbl[i].e_addr);
         @(posedge clk);
         #1;
         chk($sformatf("vec%0d id_valid", i), 32'(id_valid), 32'(tbl[i].e_val));
         chk($sformatf("vec%0d id_instr", i), id_instr,      tbl[i].e_instr);
         if (tbl[i].e_val) chk($sformatf("vec%0d id_pc", i), id_pc, tbl[i].e_pc);
      end

      // Async reset while a response sits in the skid buffer
      apply(0,0,32'h0,0,0,32'h0);
      rst_n = 1'b0;
      #2;
      rst_n = 1'b1;
      apply(0,0,32'h0,1,0,32'h0);
      apply(0,0,32'h0,1,1,32'hABCD_0001);
      apply(1,0,32'h0,1,0,32'h0);
      apply(1,0,32'h0,1,1,32'hABCD_0002);
      @(posedge clk);
      #1;
      chk("hold id_valid", 32'(id_valid), 32'h1);
      chk("hold id_pc",    id_pc,         RST_PC);
      chk("hold req",      32'(req),      32'h0);
      #2;
      rst_n = 1'b0;
      #1;
      chk("async req",      32'(req),      32'h0);
      chk("async addr",     addr,          RST_PC);
      chk("async id_valid", 32'(id_valid), 32'h0);
      chk("async id_instr", id_instr,      BUB);
      chk("async id_pc",    id_pc,         32'h0);
      apply(0,0,32'h0,0,0,32'h0);
      rst_n = 1'b1;

      m_pc = RST_PC; m_req_pc = '0; m_buf_instr = '0;
      m_id_pc = '0; m_id_instr = BUB; m_id_valid = 1'b0;
      m_out = 1'b0; m_stale = 1'b0; m_buf = 1'b0;
      m_stall_cnt = 0; m_wait_cnt = 0;
      mp = 1'b0; ma = '0; mw = 0;

      // Randomized traffic against the reference model
      for (int c = 0; c < NRAND; c++) begin
         @(negedge clk);
         stall  = ($urandom_range(0, 3) == 0);
         flush  = ($urandom_range(0, 11) == 0);
         target = ($urandom_range(0, 7) == 0) ? 32'hFFFF_FFF8 : ($urandom & 32'hFFFF_FFFC);
         ready  = ($urandom_range(0, 9) < 7);
         if (mp && mw == 0) begin
            valid = 1'b1; rdata = mem_word(ma); mp = 1'b0;
         end else begin
            valid = 1'b0; rdata = $urandom;
            if (mp) mw--;
         end
         #1;
         req_exp = !m_out && !m_buf && !flush;
         chk("rnd req", 32'(req), 32'(req_exp));
         if (req_exp) chk("rnd addr", addr, m_pc);
         chk("rnd id_valid", 32'(id_valid), 32'(m_id_valid));
         chk("rnd id_instr", id_instr, m_id_instr);
         if (m_id_valid) chk("rnd id_pc", id_pc, m_id_pc);
         if (req && ready) begin
            mp = 1'b1; ma = addr; mw = $urandom_range(0, 2);
         end

         if (stall) m_stall_cnt++;
         if (m_out && !valid) m_wait_cnt++;
         pc_old = m_pc;
         dlv = 1'b0;
         dlv_instr = '0;
         if (m_buf) begin
            if (flush) m_buf = 1'b0;
            else if (!stall) begin
               dlv = 1'b1; dlv_instr = m_buf_instr; m_buf = 1'b0;
            end
         end
         if (m_out && valid) begin
            m_out = 1'b0;
            if (!m_stale && !flush) begin
               if (stall) begin
                  m_buf = 1'b1; m_buf_instr = mem_word(m_req_pc);
               end else begin
                  dlv = 1'b1; dlv_instr = mem_word(m_req_pc);
               end
            end
            m_stale = 1'b0;
         end else if (m_out && flush) begin
            m_stale = 1'b1;
         end
         if (req_exp && ready) begin
            m_out = 1'b1; m_req_pc = m_pc;
         end
         if (flush) m_pc = target;
         else if (dlv) m_pc = m_pc + 32'd4;
         if (flush) begin
            m_id_valid = 1'b0; m_id_instr = BUB;
         end else if (!stall) begin
            if (dlv) begin
               m_id_valid = 1'b1; m_id_instr = dlv_instr; m_id_pc = pc_old;
            end else begin
               m_id_valid = 1'b0; m_id_instr = BUB;
            end
         end
      end

`ifdef IF_FETCH_PERF_EN
      @(negedge clk);
      chk("perf stall", pstall, 32'(m_stall_cnt + 32'(stall)));
      chk("perf wait",  pwait,  32'(m_wait_cnt + 32'(m_out && !valid)));
`endif

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
